// File: rtl/bus_pkg.sv
// Shared types for the system-bus read-response path.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NOSEL   = 2'b01,
    ERR_MULTI   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

endpackage

// File: rtl/bus_onehot_enc.sv
// Combinational chip-select encoder: slave index plus none/multi-select flags.
module bus_onehot_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cs_i,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o,
  output logic             multi_o
);

  // OR-ing the indices of all set bits is exact when the vector is one-hot,
  // which is the only case in which the index is used.
  always_comb begin
    index_o = '0;
    for (int k = 0; k < N; k++) begin
      if (cs_i[k]) begin
        index_o = index_o | IDX_W'(k);
      end
    end
  end

  assign any_o   = |cs_i;
  assign multi_o = |(cs_i & (cs_i - N'(1)));

endmodule

// File: rtl/bus_rsp_mux.sv
// Registered read-response multiplexer: latches the selected slave on a request,
// waits for its ready under a watchdog, and returns data or an error code.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no access in flight; m_req_i sampled, decode errors answered
//   WAIT  | waiting for s_rdy_i[sel_q] or watchdog expiry
module bus_rsp_mux
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 8,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               m_req_i,
  input  logic [NUM_SLAVES-1:0]              s_cs_i,
  input  logic [NUM_SLAVES*DATA_BUS_WIDTH-1:0] s_rd_data_i,
  input  logic [NUM_SLAVES-1:0]              s_rdy_i,
  output logic [DATA_BUS_WIDTH-1:0]          m_rd_data_o,
  output logic                               m_rdy_o,
  output logic                               m_err_o,
  output logic [1:0]                         err_code_o,
  output logic                               busy_o
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic                      rdy_q, rdy_d;
  logic                      err_q, err_d;
  err_code_e                 code_q, code_d;
  logic                      busy_q, busy_d;

  logic [SEL_W-1:0]          cs_idx;
  logic                      cs_any;
  logic                      cs_multi;
  logic                      rdy_sel;
  logic [DATA_BUS_WIDTH-1:0] data_sel;

  bus_onehot_enc #(
    .N     (NUM_SLAVES),
    .IDX_W (SEL_W)
  ) u_cs_enc (
    .cs_i    (s_cs_i),
    .index_o (cs_idx),
    .any_o   (cs_any),
    .multi_o (cs_multi)
  );

  always_comb begin
    rdy_sel  = 1'b0;
    data_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        rdy_sel  = s_rdy_i[k];
        data_sel = s_rd_data_i[k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (m_req_i) begin
          if (!cs_any || cs_multi) begin
            rdy_d  = 1'b1;
            err_d  = 1'b1;
            code_d = cs_any ? ERR_MULTI : ERR_NOSEL;
            data_d = '0;
          end else begin
            sel_d   = cs_idx;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (rdy_sel) begin
          data_d  = data_sel;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          data_d  = '0;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  assign m_rd_data_o = data_q;
  assign m_rdy_o     = rdy_q;
  assign m_err_o     = err_q;
  assign err_code_o  = code_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_bus_rsp_mux.sv
// Directed bench for bus_rsp_mux with N=8, W=32, TIMEOUT_CYCLES=4.
module tb_bus_rsp_mux;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int TO = 4;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic           m_req_i;
  logic [N-1:0]   s_cs_i;
  logic [N*W-1:0] s_rd_data_i;
  logic [N-1:0]   s_rdy_i;
  logic [W-1:0]   m_rd_data_o;
  logic           m_rdy_o;
  logic           m_err_o;
  logic [1:0]     err_code_o;
  logic           busy_o;

  int n_cmp = 0;
  int n_err = 0;

  bus_rsp_mux #(
    .NUM_SLAVES     (N),
    .DATA_BUS_WIDTH (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .m_req_i     (m_req_i),
    .s_cs_i      (s_cs_i),
    .s_rd_data_i (s_rd_data_i),
    .s_rdy_i     (s_rdy_i),
    .m_rd_data_o (m_rd_data_o),
    .m_rdy_o     (m_rdy_o),
    .m_err_o     (m_err_o),
    .err_code_o  (err_code_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic rdy, input logic err,
                         input logic [1:0] code, input logic [31:0] data, input logic busy);
    chk({tag, ".rdy"},  32'(m_rdy_o),    32'(rdy));
    chk({tag, ".err"},  32'(m_err_o),    32'(err));
    chk({tag, ".code"}, 32'(err_code_o), 32'(code));
    chk({tag, ".data"}, m_rd_data_o,     data);
    chk({tag, ".busy"}, 32'(busy_o),     32'(busy));
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_data(input int k, input logic [31:0] v);
    s_rd_data_i[k*W +: W] = v;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    m_req_i     = 1'b0;
    s_cs_i      = '0;
    s_rd_data_i = '0;
    s_rdy_i     = '0;
    set_data(0, 32'h0BAD0BAD);
    set_data(2, 32'hDEADBEEF);
    set_data(5, 32'h55AA1234);
    tick();
    chk_rsp("reset", 0, 0, 2'b00, 32'h0, 0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // normal read, ready already high
    m_req_i = 1; s_cs_i = 8'h04; s_rdy_i = 8'h04;
    tick();
    chk_rsp("norm.t1", 0, 0, 2'b00, 32'h0, 1);
    m_req_i = 0;
    tick();
    chk_rsp("norm.t2", 1, 0, 2'b00, 32'hDEADBEEF, 0);
    s_rdy_i = 0;
    tick();
    chk_rsp("norm.t3", 0, 0, 2'b00, 32'hDEADBEEF, 0);

    // wait states with distractions on cs, req and slave 0 ready
    m_req_i = 1; s_cs_i = 8'h20; s_rdy_i = 0;
    tick();
    chk_rsp("ws.t1", 0, 0, 2'b00, 32'hDEADBEEF, 1);
    m_req_i = 0; s_cs_i = 8'h01; s_rdy_i = 8'h01;
    tick();
    chk_rsp("ws.t2", 0, 0, 2'b00, 32'hDEADBEEF, 1);
    m_req_i = 1; s_cs_i = 8'hFF; s_rdy_i = 8'h00;
    tick();
    chk_rsp("ws.t3", 0, 0, 2'b00, 32'hDEADBEEF, 1);
    m_req_i = 0; s_cs_i = 8'h00; s_rdy_i = 8'h21;
    tick();
    chk_rsp("ws.t4", 1, 0, 2'b00, 32'h55AA1234, 0);
    s_rdy_i = 0;
    tick();

    // timeout, ready never arrives
    m_req_i = 1; s_cs_i = 8'h04;
    tick();
    m_req_i = 0;
    for (int i = 1; i <= TO; i++) begin
      chk_rsp($sformatf("to.t%0d", i), 0, 0, 2'b00, 32'h55AA1234, 1);
      tick();
    end
    chk_rsp("to.t5", 1, 1, 2'b11, 32'h0, 0);
    tick();
    chk_rsp("to.t6", 0, 0, 2'b00, 32'h0, 0);

    // ready in the last watchdog cycle beats the timeout
    m_req_i = 1; s_cs_i = 8'h04;
    tick();
    m_req_i = 0;
    tick(); tick(); tick();
    s_rdy_i = 8'h04;
    tick();
    chk_rsp("late.t5", 1, 0, 2'b00, 32'hDEADBEEF, 0);
    s_rdy_i = 0;

    // decode errors
    m_req_i = 1; s_cs_i = 8'h00;
    tick();
    chk_rsp("nosel", 1, 1, 2'b01, 32'h0, 0);
    s_cs_i = 8'h11;
    tick();
    chk_rsp("multi", 1, 1, 2'b10, 32'h0, 0);
    m_req_i = 0;
    tick();
    chk_rsp("dec.idle", 0, 0, 2'b00, 32'h0, 0);

    // back-to-back: second request issued in the response cycle
    m_req_i = 1; s_cs_i = 8'h04; s_rdy_i = 8'h05;
    tick();
    m_req_i = 0;
    tick();
    chk_rsp("b2b.r1", 1, 0, 2'b00, 32'hDEADBEEF, 0);
    m_req_i = 1; s_cs_i = 8'h01;
    tick();
    chk_rsp("b2b.w2", 0, 0, 2'b00, 32'hDEADBEEF, 1);
    m_req_i = 0;
    tick();
    chk_rsp("b2b.r2", 1, 0, 2'b00, 32'h0BAD0BAD, 0);
    s_rdy_i = 0;

    // reset in the middle of WAIT
    m_req_i = 1; s_cs_i = 8'h20;
    tick();
    m_req_i = 0;
    chk_rsp("rstw.t1", 0, 0, 2'b00, 32'h0BAD0BAD, 1);
    tick();
    rst_n_i = 0;
    #1;
    chk_rsp("rstw.async", 0, 0, 2'b00, 32'h0, 0);
    s_rdy_i = 8'h20;
    tick();
    rst_n_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp($sformatf("rstw.post%0d", i), 0, 0, 2'b00, 32'h0, 0);
    end
    m_req_i = 1; s_cs_i = 8'h20;
    tick();
    m_req_i = 0;
    chk_rsp("rstw.new1", 0, 0, 2'b00, 32'h0, 1);
    tick();
    chk_rsp("rstw.new2", 1, 0, 2'b00, 32'h55AA1234, 0);
    s_rdy_i = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
